// File: rtl/usb_pkg.sv
// Shared constants and types for the USB receive path.
package usb_pkg;

    localparam int CRC16_BYTES = 2;
    localparam int SETUP_LEN   = 8;

    // Byte offsets of the fields inside an 8-byte SETUP payload.
    localparam int SETUP_OFS_BMRT = 0;
    localparam int SETUP_OFS_BREQ = 1;
    localparam int SETUP_OFS_WVAL = 2;
    localparam int SETUP_OFS_WIDX = 4;
    localparam int SETUP_OFS_WLEN = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        OVF  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/usb_setup_latch.sv
// SETUP shadow: captures the first 8 stored bytes of a packet and publishes
// them as decoded fields when the packet is committed as a valid SETUP.
module usb_setup_latch
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst0_async,
    input  logic        clr_i,
    input  logic        wr_stb_i,
    input  logic [7:0]  wr_data_i,
    input  logic        restart_i,
    input  logic        load_i,
    output logic [7:0]  bm_request_type_o,
    output logic [7:0]  b_request_o,
    output logic [15:0] w_value_o,
    output logic [15:0] w_index_o,
    output logic [15:0] w_length_o,
    output logic        setup_valid_o
);

    logic [3:0] idx_q;
    logic [7:0] shadow_q [SETUP_LEN];
    logic [7:0] bmrt_q, breq_q;
    logic [15:0] wval_q, widx_q, wlen_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            bmrt_q  <= '0;
            breq_q  <= '0;
            wval_q  <= '0;
            widx_q  <= '0;
            wlen_q  <= '0;
            for (int i = 0; i < SETUP_LEN; i++) shadow_q[i] <= '0;
        end else if (clr_i) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            bmrt_q  <= '0;
            breq_q  <= '0;
            wval_q  <= '0;
            widx_q  <= '0;
            wlen_q  <= '0;
            for (int i = 0; i < SETUP_LEN; i++) shadow_q[i] <= '0;
        end else begin
            valid_q <= load_i;
            // Index saturates at 8 so trailing CRC bytes never disturb the shadow.
            if (restart_i) begin
                idx_q <= '0;
            end else if (wr_stb_i && (idx_q < 4'(SETUP_LEN))) begin
                shadow_q[idx_q[2:0]] <= wr_data_i;
                idx_q                <= idx_q + 4'd1;
            end
            if (load_i) begin
                bmrt_q <= shadow_q[SETUP_OFS_BMRT];
                breq_q <= shadow_q[SETUP_OFS_BREQ];
                wval_q <= {shadow_q[SETUP_OFS_WVAL+1], shadow_q[SETUP_OFS_WVAL]};
                widx_q <= {shadow_q[SETUP_OFS_WIDX+1], shadow_q[SETUP_OFS_WIDX]};
                wlen_q <= {shadow_q[SETUP_OFS_WLEN+1], shadow_q[SETUP_OFS_WLEN]};
            end
        end
    end

    assign bm_request_type_o = bmrt_q;
    assign b_request_o       = breq_q;
    assign w_value_o         = wval_q;
    assign w_index_o         = widx_q;
    assign w_length_o        = wlen_q;
    assign setup_valid_o     = valid_q;

endmodule

// File: rtl/usb_rcv_pktbuf.sv
// Receive packet buffer with speculative write, commit (CRC strip) and rewind.
// SETUP decoding is built only when USB_RCV_SETUP_DECODE_EN is defined.
module usb_rcv_pktbuf
    import usb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst0_async,
    input  logic                  rst0_sync,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  wr_setup,
    input  logic                  wr_commit,
    input  logic                  wr_discard,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  pkt_done,
    output logic [ADDR_WIDTH:0]   pkt_len,
    output logic                  pkt_err,
    output logic [7:0]            bm_request_type,
    output logic [7:0]            b_request,
    output logic [15:0]           w_value,
    output logic [15:0]           w_index,
    output logic [15:0]           w_length,
    output logic                  setup_valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pkt_len_q, pkt_len_d;
    logic          pkt_done_q, pkt_done_d, pkt_err_q, pkt_err_d;
    rx_state_e     state_q, state_d;

    logic [PW-1:0] n_pend;
    logic          wr_store, commit_ok;

    assign fifo_full  = (PW'(wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign fifo_empty = (rd_ptr_q == cmt_ptr_q);
    assign n_pend     = wr_ptr_q - cmt_ptr_q;
    assign commit_ok  = (state_q != OVF) && (n_pend >= PW'(CRC16_BYTES));
    assign wr_store   = wr_en && !wr_commit && !wr_discard && !fifo_full && (state_q != OVF);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_len_d  = pkt_len_q;
        pkt_done_d = 1'b0;
        pkt_err_d  = 1'b0;
        if (wr_discard) begin
            state_d  = IDLE;
            wr_ptr_d = cmt_ptr_q;
        end else if (wr_commit) begin
            state_d = IDLE;
            if (commit_ok) begin
                wr_ptr_d   = wr_ptr_q - PW'(CRC16_BYTES);
                cmt_ptr_d  = wr_ptr_q - PW'(CRC16_BYTES);
                pkt_len_d  = n_pend - PW'(CRC16_BYTES);
                pkt_done_d = 1'b1;
            end else begin
                wr_ptr_d  = cmt_ptr_q;
                pkt_err_d = 1'b1;
            end
        end else if (wr_en) begin
            case (state_q)
                IDLE:    state_d = RECV;
                RECV:    if (fifo_full) state_d = OVF;
                default: state_d = state_q;
            endcase
            if (wr_store) wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en && !fifo_empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            pkt_len_q  <= '0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else if (!rst0_sync) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            pkt_len_q  <= '0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_len_q  <= pkt_len_d;
            pkt_done_q <= pkt_done_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_store) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end

    // Empty buffer reads as zero so stale memory never leaks out.
    assign rd_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign pkt_done = pkt_done_q;
    assign pkt_err  = pkt_err_q;
    assign pkt_len  = pkt_len_q;

`ifdef USB_RCV_SETUP_DECODE_EN
    logic setup_load;
    assign setup_load = wr_commit && !wr_discard && commit_ok && wr_setup &&
                        (int'(n_pend) == SETUP_LEN + CRC16_BYTES);

    usb_setup_latch u_setup (
        .clk               (clk),
        .rst0_async        (rst0_async),
        .clr_i             (!rst0_sync),
        .wr_stb_i          (wr_store),
        .wr_data_i         (wr_data),
        .restart_i         (wr_commit || wr_discard),
        .load_i            (setup_load),
        .bm_request_type_o (bm_request_type),
        .b_request_o       (b_request),
        .w_value_o         (w_value),
        .w_index_o         (w_index),
        .w_length_o        (w_length),
        .setup_valid_o     (setup_valid)
    );
`else
    wire unused_setup = &{1'b0, wr_setup};
    assign bm_request_type = '0;
    assign b_request       = '0;
    assign w_value         = '0;
    assign w_index         = '0;
    assign w_length        = '0;
    assign setup_valid     = 1'b0;
`endif

endmodule
